// File: rtl/nios_pio_in_ctrl.sv
// -----------------------------------------------------------------------------
// nios_pio_in_ctrl
// Sampling/debounce controller for the Nios input PIO path.
//   - 2-FF synchroniser per input bit
//   - per-bit debounce FSM evaluated on a divided sampling tick
//   - per-bit edge capture (write-1-to-clear) and maskable level IRQ
//   - Avalon-MM slave s1 with registered, zero-wait-state read data
//
// Optional feature: define PIO_IN_TIMESTAMP_EN to add a 32-bit free-running
// cycle counter latched into TSTAMP (address 3) whenever an edge is captured.
// Without it address 3 reads 0 and no counter logic exists.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    register select: 0 DATA, 1 MASK, 2 EDGE, 3 TSTAMP/zero
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data (only the low WIDTH bits are meaningful)
//   readdata   registered read data, 1-cycle latency
//   in_port    raw asynchronous inputs
//   irq        level interrupt = |(EDGE & MASK), registered
// -----------------------------------------------------------------------------
module nios_pio_in_ctrl #(
   parameter int WIDTH     = 4,
   parameter int TICK_DIV  = 1000,
   parameter int DEB_CNT   = 4,
   parameter int EDGE_TYPE = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic {ST_STABLE, ST_PEND} deb_state_e;

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
   logic             tick;
   deb_state_e       state_q [WIDTH];
   deb_state_e       state_d [WIDTH];
   logic [3:0]       cnt_q   [WIDTH];
   logic [3:0]       cnt_d   [WIDTH];
   logic [WIDTH-1:0] deb_q, deb_d, deb_prev_q;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] mask_q, mask_d, edge_q, edge_d;
   logic             irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign tick         = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign unused_wdata = ^writedata;

`ifdef PIO_IN_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_q, ts_d;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; an incomplete if/case here would infer a latch.
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

      for (int i = 0; i < WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         deb_d[i]   = deb_q[i];
         if (tick) begin
            case (state_q[i])
               ST_STABLE: begin
                  cnt_d[i] = '0;
                  if (sync2_q[i] != deb_q[i]) begin
                     // A single agreeing tick is enough when DEB_CNT is 1.
                     if (DEB_CNT == 1) begin
                        deb_d[i] = sync2_q[i];
                     end else begin
                        state_d[i] = ST_PEND;
                        cnt_d[i]   = 4'd1;
                     end
                  end
               end
               ST_PEND: begin
                  if (sync2_q[i] == deb_q[i]) begin
                     state_d[i] = ST_STABLE;
                     cnt_d[i]   = '0;
                  end else if ((cnt_q[i] + 4'd1) == 4'(DEB_CNT)) begin
                     deb_d[i]   = sync2_q[i];
                     state_d[i] = ST_STABLE;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i]   = cnt_q[i] + 4'd1;
                  end
               end
               default: begin
                  state_d[i] = ST_STABLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end

      case (EDGE_TYPE)
         0:       edge_evt = deb_q & ~deb_prev_q;
         1:       edge_evt = ~deb_q & deb_prev_q;
         default: edge_evt = deb_q ^ deb_prev_q;
      endcase

      mask_d = mask_q;
      if (wr_en && address == 2'd1) mask_d = writedata[WIDTH-1:0];

      // Clear first, then OR in new edges so a same-cycle capture wins.
      edge_d = edge_q;
      if (wr_en && address == 2'd2) edge_d = edge_q & ~writedata[WIDTH-1:0];
      edge_d = edge_d | edge_evt;

      irq_d = |(edge_q & mask_q);

`ifdef PIO_IN_TIMESTAMP_EN
      ts_d = (|edge_evt) ? ts_cnt_q : ts_q;
`endif

      rdata_d = '0;
      case (address)
         2'd0: rdata_d[WIDTH-1:0] = deb_q;
         2'd1: rdata_d[WIDTH-1:0] = mask_q;
         2'd2: rdata_d[WIDTH-1:0] = edge_q;
         default: begin
`ifdef PIO_IN_TIMESTAMP_EN
            rdata_d = ts_q;
`else
            rdata_d = '0;
`endif
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         tick_cnt_q <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         mask_q     <= '0;
         edge_q     <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q    <= in_port;
         sync2_q    <= sync1_q;
         tick_cnt_q <= tick_cnt_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef PIO_IN_TIMESTAMP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_cnt_q <= '0;
         ts_q     <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         ts_q     <= ts_d;
      end
   end
`endif

   assign readdata = rdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_nios_pio_in_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nios_pio_in_ctrl
// Directed bench for nios_pio_in_ctrl with TICK_DIV=4, DEB_CNT=3, rising edges.
// Register reads push their expected value into a queue when issued and pop it
// when the registered readdata appears one clock later.
// -----------------------------------------------------------------------------
module tb_nios_pio_in_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  in_port;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   always #5 clk = ~clk;

   nios_pio_in_ctrl #(
      .WIDTH     (4),
      .TICK_DIV  (4),
      .DEB_CNT   (3),
      .EDGE_TYPE (0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      cyc(1);
      check(tag_q.pop_front(), readdata, exp_q.pop_front());
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cyc(1);
      write_n    = 1'b1;
      chipselect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;

      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'h0;
      cyc(3);
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      cyc(1);

      rd(2'd0, 32'h0, "init_data");
      rd(2'd1, 32'h0, "init_mask");
      rd(2'd2, 32'h0, "init_edge");
      rd(2'd3, 32'h0, "init_addr3");

      // Glitch: high for exactly 8 clocks (two sample ticks) then low.
      in_port = 4'h1;
      cyc(8);
      in_port = 4'h0;
      cyc(20);
      rd(2'd0, 32'h0, "glitch_data");
      rd(2'd2, 32'h0, "glitch_edge");
      check("glitch_irq", {31'b0, irq}, 32'h0);

      // Debounce: readdata must stay 0 for 11 clocks, then show 1 by clock 20.
      address    = 2'd0;
      chipselect = 1'b1;
      in_port    = 4'h1;
      found      = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         cyc(1);
         if (readdata !== 32'h0) found = 1'b1;
      end
      check("deb_not_early", {31'b0, found}, 32'h0);
      for (int i = 12; i <= 20 && !found; i++) begin
         cyc(1);
         if (readdata === 32'h1) found = 1'b1;
      end
      check("deb_settled", {31'b0, found}, 32'h1);
      rd(2'd0, 32'h1, "deb_data");
      rd(2'd2, 32'h1, "deb_edge");
`ifdef PIO_IN_TIMESTAMP_EN
      address = 2'd3;
      cyc(1);
      check("tstamp_nonzero", {31'b0, readdata != 32'h0}, 32'h1);
`else
      rd(2'd3, 32'h0, "addr3_zero");
`endif

      wr(2'd2, 32'h2);
      rd(2'd2, 32'h1, "edge_w0_untouched");
      check("mask0_irq", {31'b0, irq}, 32'h0);
      wr(2'd0, 32'hFF);
      rd(2'd0, 32'h1, "data_ro");
      wr(2'd2, 32'h1);
      rd(2'd2, 32'h0, "edge_w1c");

      // IRQ path.
      wr(2'd1, 32'hFFFF_FFF2);
      rd(2'd1, 32'h2, "mask_width");
      in_port = 4'h3;
      cyc(20);
      rd(2'd2, 32'h2, "irq_edge");
      check("irq_set", {31'b0, irq}, 32'h1);
      wr(2'd2, 32'h2);
      cyc(1);
      check("irq_clear", {31'b0, irq}, 32'h0);
      rd(2'd2, 32'h0, "irq_edge_clr");

      in_port = 4'h2;
      cyc(20);
      rd(2'd2, 32'h0, "fall_ignored");
      in_port = 4'h3;
      cyc(20);
      rd(2'd2, 32'h1, "bit0_edge");
      check("bit0_irq_masked", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h1);

      // Collision: clear bit0 every clock while it rises; only a capture that
      // beats the clear can ever appear in readdata.
      in_port = 4'h2;
      cyc(20);
      in_port    = 4'h3;
      address    = 2'd2;
      writedata  = 32'h1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      found      = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cyc(1);
         if (readdata[0] === 1'b1) found = 1'b1;
      end
      write_n    = 1'b1;
      chipselect = 1'b0;
      check("collision_set_wins", {31'b0, found}, 32'h1);
      rd(2'd0, 32'h3, "collision_data");

      // Reset mid-run with state populated.
      in_port = 4'h1;
      cyc(20);
      in_port = 4'h3;
      cyc(20);
      check("pre_reset_irq", {31'b0, irq}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("midrst_readdata", readdata, 32'h0);
      check("midrst_irq", {31'b0, irq}, 32'h0);
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
      rd(2'd0, 32'h0, "post_rst_data");
      rd(2'd2, 32'h0, "post_rst_edge");
      rd(2'd1, 32'h0, "post_rst_mask");
      rd(2'd3, 32'h0, "post_rst_addr3");
      check("post_rst_irq", {31'b0, irq}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
